// File: rtl/control_unit_pkg.sv
// Shared types and field layout for the control unit.
// Provides state_t, op_class_t, opcode constants, field positions, classify().
package cu_pkg;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    LD_RD,
    LD_WB,
    ST,
    EX,
    HALT
  } state_t;

  typedef enum logic [2:0] {
    C_NOP,
    C_LOAD,
    C_STORE,
    C_HALT,
    C_ALU,
    C_ILL
  } op_class_t;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_LOAD  = 4'h1;
  localparam logic [3:0] OP_STORE = 4'h2;
  localparam logic [3:0] OP_HALT  = 4'h3;

  localparam int OP_ALU_BIT = 3;

  localparam int OP_LSB   = 12;
  localparam int RD_LSB   = 8;
  localparam int RA_LSB   = 4;
  localparam int RB_LSB   = 0;
  localparam int ADDR_LSB = 0;

  function automatic op_class_t classify(
    input logic [3:0] op
  );
    op_class_t c;
    if (op[OP_ALU_BIT]) begin
      c = C_ALU;
    end else begin
      unique case (op)
        OP_NOP:   c = C_NOP;
        OP_LOAD:  c = C_LOAD;
        OP_STORE: c = C_STORE;
        OP_HALT:  c = C_HALT;
        default:  c = C_ILL;
      endcase
    end
    return c;
  endfunction

endpackage

// File: rtl/control_unit_if.sv
// Data path control bundle driven by the sequencer.
// master: control_unit drives; slave: data path consumes.
interface control_unit_if #(
  parameter int D_ADDR_W = 8,
  parameter int R_ADDR_W = 4
);

  logic [D_ADDR_W-1:0] D_addr;
  logic                D_wr;
  logic                RF_s;
  logic                RF_W_en;
  logic [R_ADDR_W-1:0] RF_W_addr;
  logic [R_ADDR_W-1:0] RF_A_addr;
  logic [R_ADDR_W-1:0] RF_B_addr;
  logic [3:0]          ALU_sel;

  modport master (
    output D_addr, D_wr, RF_s, RF_W_en,
    output RF_W_addr, RF_A_addr, RF_B_addr,
    output ALU_sel
  );

  modport slave (
    input D_addr, D_wr, RF_s, RF_W_en,
    input RF_W_addr, RF_A_addr, RF_B_addr,
    input ALU_sel
  );

endinterface

// File: rtl/control_unit_decode.sv
// Combinational instruction decode: word -> op class and fields.
// Ports: ir in; op_class, rd, ra, rb, addr, alu_sel out.
module cu_decode
  import cu_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int D_ADDR_W = 8,
  parameter int R_ADDR_W = 4
) (
  input  logic [WIDTH-1:0]    ir,
  output op_class_t           op_class,
  output logic [R_ADDR_W-1:0] rd,
  output logic [R_ADDR_W-1:0] ra,
  output logic [R_ADDR_W-1:0] rb,
  output logic [D_ADDR_W-1:0] addr,
  output logic [3:0]          alu_sel
);

  logic [3:0] op;

  assign op       = ir[OP_LSB +: 4];
  assign op_class = classify(op);
  assign rd       = ir[RD_LSB +: R_ADDR_W];
  assign ra       = ir[RA_LSB +: R_ADDR_W];
  assign rb       = ir[RB_LSB +: R_ADDR_W];
  assign addr     = ir[ADDR_LSB +: D_ADDR_W];
  assign alu_sel  = {1'b0, op[2:0]};

endmodule

// File: rtl/control_unit.sv
// Multi-cycle sequencer driving data path control from a sync ROM.
// Ports: clk, rst, [step if CU_SINGLE_STEP_EN], I_addr, I_data, dp, halted, illegal.
module control_unit
  import cu_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int I_ADDR_W = 8,
  parameter int D_ADDR_W = 8,
  parameter int R_ADDR_W = 4
) (
  input  logic                clk,
  input  logic                rst,
`ifdef CU_SINGLE_STEP_EN
  input  logic                step,
`endif
  output logic [I_ADDR_W-1:0] I_addr,
  input  logic [WIDTH-1:0]    I_data,
  control_unit_if.master      dp,
  output logic                halted,
  output logic                illegal
);

  state_t              state;
  state_t              cur;
  logic [I_ADDR_W-1:0] pc;
  logic [WIDTH-1:0]    ir;
  logic                illegal_q;
  logic                go;

  logic [WIDTH-1:0]    dec_in;
  op_class_t           op_class;
  logic [R_ADDR_W-1:0] rd;
  logic [R_ADDR_W-1:0] ra;
  logic [R_ADDR_W-1:0] rb;
  logic [D_ADDR_W-1:0] addr;
  logic [3:0]          alu_sel;

`ifdef CU_SINGLE_STEP_EN
  assign go = step;
`else
  assign go = 1'b1;
`endif

  // DECODE classifies the fresh ROM word; other states use the latched IR.
  assign dec_in = (state == DECODE) ? I_data : ir;

  cu_decode #(
    .WIDTH    (WIDTH),
    .D_ADDR_W (D_ADDR_W),
    .R_ADDR_W (R_ADDR_W)
  ) u_dec (
    .ir       (dec_in),
    .op_class (op_class),
    .rd       (rd),
    .ra       (ra),
    .rb       (rb),
    .addr     (addr),
    .alu_sel  (alu_sel)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FETCH;
      pc        <= '0;
      ir        <= '0;
      illegal_q <= 1'b0;
    end else begin
      unique case (state)
        FETCH: begin
          if (go) state <= DECODE;
        end
        DECODE: begin
          ir <= I_data;
          pc <= pc + 1'b1;
          unique case (op_class)
            C_LOAD:  state <= LD_RD;
            C_STORE: state <= ST;
            C_ALU:   state <= EX;
            C_HALT:  state <= HALT;
            default: state <= FETCH;
          endcase
          if (op_class == C_ILL) illegal_q <= 1'b1;
        end
        LD_RD:   state <= LD_WB;
        LD_WB:   state <= FETCH;
        ST:      state <= FETCH;
        EX:      state <= FETCH;
        HALT:    state <= HALT;
        default: state <= FETCH;
      endcase
    end
  end

  // Reset gates the state seen by the output decode so that a write
  // strobe in progress is dropped in the reset cycle itself.
  assign cur = rst ? FETCH : state;

  always_comb begin
    dp.D_addr    = '0;
    dp.D_wr      = 1'b0;
    dp.RF_s      = 1'b0;
    dp.RF_W_en   = 1'b0;
    dp.RF_W_addr = '0;
    dp.RF_A_addr = '0;
    dp.RF_B_addr = '0;
    dp.ALU_sel   = '0;
    unique case (cur)
      LD_RD: begin
        dp.D_addr = addr;
        dp.RF_s   = 1'b1;
      end
      LD_WB: begin
        dp.D_addr    = addr;
        dp.RF_s      = 1'b1;
        dp.RF_W_addr = rd;
        dp.RF_W_en   = 1'b1;
      end
      ST: begin
        dp.D_addr    = addr;
        dp.RF_A_addr = rd;
        dp.D_wr      = 1'b1;
      end
      EX: begin
        dp.RF_A_addr = ra;
        dp.RF_B_addr = rb;
        dp.ALU_sel   = alu_sel;
        dp.RF_W_addr = rd;
        dp.RF_W_en   = 1'b1;
      end
      default: ;
    endcase
  end

  assign I_addr  = pc;
  assign halted  = (cur == HALT);
  assign illegal = illegal_q;

endmodule
